// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: default widths,
// bubble instruction and skid-buffer occupancy state encoding.
package pipe_pkg;

    localparam int ADDR_W_DEF  = 16;
    localparam int INSTR_W_DEF = 16;
    localparam logic [15:0] NOP_WORD_DEF = 16'h0800;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_skid_entry.sv
// One pipeline entry: valid bit plus address and instruction, with load and
// clear; a cleared entry shows the NOP bubble and keeps its last address.
module pipe_skid_entry
    import pipe_pkg::*;
#(
    parameter int                 ADDR_W   = ADDR_W_DEF,
    parameter int                 INSTR_W  = INSTR_W_DEF,
    parameter logic [INSTR_W-1:0] NOP_WORD = NOP_WORD_DEF
) (
    input  logic               pii_clk,
    input  logic               pii_rst,
    input  logic               load_i,
    input  logic               clear_i,
    input  logic [ADDR_W-1:0]  addr_i,
    input  logic [INSTR_W-1:0] instr_i,
    output logic               valid_o,
    output logic [ADDR_W-1:0]  addr_o,
    output logic [INSTR_W-1:0] instr_o
);

    logic               valid_q, valid_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [INSTR_W-1:0] instr_q, instr_d;

    // Next-state: clear (flush/drain) wins over load.
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        if (clear_i) begin
            valid_d = 1'b0;
            instr_d = NOP_WORD;
        end else if (load_i) begin
            valid_d = 1'b1;
            addr_d  = addr_i;
            instr_d = instr_i;
        end else begin
            valid_d = valid_q;
        end
    end

    // Entry storage register.
    always_ff @(posedge pii_clk or negedge pii_rst) begin
        if (!pii_rst) begin
            valid_q <= 1'b0;
            addr_q  <= {ADDR_W{1'b0}};
            instr_q <= NOP_WORD;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
        end
    end

    assign valid_o = valid_q;
    assign addr_o  = addr_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with flush-to-bubble and an optional
// two-entry skid buffer that makes upstream ready a registered signal.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                 ADDR_W   = ADDR_W_DEF,
    parameter int                 INSTR_W  = INSTR_W_DEF,
    parameter logic [INSTR_W-1:0] NOP_WORD = NOP_WORD_DEF,
    parameter int                 SKID     = 1
) (
    input  logic               pii_clk,
    input  logic               pii_rst,
    input  logic               pii_valid,
    input  logic [ADDR_W-1:0]  pii_addr,
    input  logic [INSTR_W-1:0] pii_instr,
    output logic               pio_ready,
    output logic               pio_valid,
    output logic [ADDR_W-1:0]  pio_addr,
    output logic [INSTR_W-1:0] pio_instr,
    input  logic               pii_ready,
    input  logic               pii_flush,
    output logic [1:0]         pio_count
);

    logic               head_load_s, head_clear_s, head_sel_skid_s, head_valid_s;
    logic [ADDR_W-1:0]  skid_addr_s, head_addr_in_s;
    logic [INSTR_W-1:0] skid_instr_s, head_instr_in_s;

    assign head_addr_in_s  = head_sel_skid_s ? skid_addr_s  : pii_addr;
    assign head_instr_in_s = head_sel_skid_s ? skid_instr_s : pii_instr;

    pipe_skid_entry #(
        .ADDR_W   (ADDR_W),
        .INSTR_W  (INSTR_W),
        .NOP_WORD (NOP_WORD)
    ) u_head (
        .pii_clk (pii_clk),
        .pii_rst (pii_rst),
        .load_i  (head_load_s),
        .clear_i (head_clear_s),
        .addr_i  (head_addr_in_s),
        .instr_i (head_instr_in_s),
        .valid_o (head_valid_s),
        .addr_o  (pio_addr),
        .instr_o (pio_instr)
    );

    assign pio_valid = head_valid_s;

    generate
        if (SKID != 0) begin : g_skid
            state_e state_q, state_d;
            logic   ready_q, accept_s, consume_s;
            logic   skid_load_s, skid_clear_s, skid_valid_s;

            assign accept_s  = pii_valid & ready_q;
            assign consume_s = head_valid_s & pii_ready;

            pipe_skid_entry #(
                .ADDR_W   (ADDR_W),
                .INSTR_W  (INSTR_W),
                .NOP_WORD (NOP_WORD)
            ) u_skid (
                .pii_clk (pii_clk),
                .pii_rst (pii_rst),
                .load_i  (skid_load_s),
                .clear_i (skid_clear_s),
                .addr_i  (pii_addr),
                .instr_i (pii_instr),
                .valid_o (skid_valid_s),
                .addr_o  (skid_addr_s),
                .instr_o (skid_instr_s)
            );

            // State and registered upstream ready; ready drops only when FULL.
            always_ff @(posedge pii_clk or negedge pii_rst) begin
                if (!pii_rst) begin
                    state_q <= ST_EMPTY;
                    ready_q <= 1'b0;
                end else begin
                    state_q <= state_d;
                    ready_q <= (state_d != ST_FULL);
                end
            end

            // Occupancy next-state; flush overrides every transfer.
            always_comb begin
                state_d = state_q;
                if (pii_flush) begin
                    state_d = ST_EMPTY;
                end else begin
                    case (state_q)
                        ST_EMPTY: state_d = accept_s ? ST_ONE : ST_EMPTY;
                        ST_ONE: begin
                            if (accept_s && !consume_s)      state_d = ST_FULL;
                            else if (consume_s && !accept_s) state_d = ST_EMPTY;
                            else                             state_d = ST_ONE;
                        end
                        ST_FULL:  state_d = consume_s ? ST_ONE : ST_FULL;
                        default:  state_d = ST_EMPTY;
                    endcase
                end
            end

            // Entry load/clear controls derived from state and transfers.
            always_comb begin
                head_load_s     = 1'b0;
                head_clear_s    = 1'b0;
                head_sel_skid_s = 1'b0;
                skid_load_s     = 1'b0;
                skid_clear_s    = 1'b0;
                if (pii_flush) begin
                    head_clear_s = 1'b1;
                    skid_clear_s = 1'b1;
                end else begin
                    case (state_q)
                        ST_EMPTY: head_load_s = accept_s;
                        ST_ONE: begin
                            if (accept_s && consume_s) head_load_s  = 1'b1;
                            else if (accept_s)         skid_load_s  = 1'b1;
                            else if (consume_s)        head_clear_s = 1'b1;
                            else                       head_load_s  = 1'b0;
                        end
                        ST_FULL: begin
                            if (consume_s) begin
                                head_load_s     = 1'b1;
                                head_sel_skid_s = 1'b1;
                                skid_clear_s    = 1'b1;
                            end else begin
                                head_load_s = 1'b0;
                            end
                        end
                        default: begin
                            head_clear_s = 1'b1;
                            skid_clear_s = 1'b1;
                        end
                    endcase
                end
            end

            assign pio_ready = ready_q;
            assign pio_count = {skid_valid_s, head_valid_s & ~skid_valid_s};
        end else begin : g_single
            logic accept_s, consume_s;

            assign pio_ready       = ~head_valid_s | pii_ready;
            assign accept_s        = pii_valid & pio_ready;
            assign consume_s       = head_valid_s & pii_ready;
            assign skid_addr_s     = {ADDR_W{1'b0}};
            assign skid_instr_s    = NOP_WORD;
            assign head_sel_skid_s = 1'b0;

            // Single-register control: accept replaces the head, drain leaves a bubble.
            always_comb begin
                head_load_s  = 1'b0;
                head_clear_s = 1'b0;
                if (pii_flush)      head_clear_s = 1'b1;
                else if (accept_s)  head_load_s  = 1'b1;
                else if (consume_s) head_clear_s = 1'b1;
                else                head_load_s  = 1'b0;
            end

            assign pio_count = {1'b0, head_valid_s};
        end
    endgenerate

endmodule
